// File: rtl/game_flow_if.sv
// Signal bundle between the game sequencer and the surrounding game logic.
// The slave side is the sequencer. The master side is the frame timing, the buttons and the object blocks.
interface game_flow_if;
    logic       startOfFrame;
    logic       start_pressed;
    logic       player_died;
    logic       player_eat_dimond;
    logic [2:0] game_state;
    logic       freeze;
    logic       level_load;
    logic       respawn;
    logic [3:0] level;
    logic [2:0] lives;
    logic [4:0] diamonds_left;

    modport master (
        output startOfFrame, start_pressed, player_died, player_eat_dimond,
        input  game_state, freeze, level_load, respawn, level, lives, diamonds_left
    );

    modport slave (
        input  startOfFrame, start_pressed, player_died, player_eat_dimond,
        output game_state, freeze, level_load, respawn, level, lives, diamonds_left
    );
endinterface

// File: rtl/game_flow_controller.sv
// Digger game sequencer: title, level load, play, death, level clear and game over.
// Timed phases count startOfFrame pulses. Every output comes straight from a register.
module game_flow_controller #(
    parameter int unsigned DIAMONDS_PER_LEVEL = 8,
    parameter int unsigned MAX_LEVEL          = 8,
    parameter int unsigned START_LIVES        = 3,
    parameter int unsigned DEATH_FRAMES       = 90,
    parameter int unsigned CLEAR_FRAMES       = 120,
    parameter int unsigned OVER_FRAMES        = 60
) (
    input  logic       clk,
    input  logic       reset,
    game_flow_if.slave gf
);
    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LOAD       = 3'd1,
        S_PLAY       = 3'd2,
        S_DYING      = 3'd3,
        S_RESPAWN    = 3'd4,
        S_LEVEL_DONE = 3'd5,
        S_GAME_OVER  = 3'd6
    } state_t;

    localparam logic [4:0] DIAMONDS_INIT = 5'(DIAMONDS_PER_LEVEL);
    localparam logic [3:0] LEVEL_LAST    = 4'(MAX_LEVEL);
    localparam logic [2:0] LIVES_INIT    = 3'(START_LIVES);
    localparam logic [7:0] DEATH_LAST    = 8'(DEATH_FRAMES - 1);
    localparam logic [7:0] CLEAR_LAST    = 8'(CLEAR_FRAMES - 1);
    localparam logic [7:0] OVER_DONE     = 8'(OVER_FRAMES);

    state_t     state_q;
    logic       start_q;
    logic [7:0] frame_q;
    logic       freeze_q;
    logic       level_load_q;
    logic       respawn_q;
    logic [3:0] level_q;
    logic [2:0] lives_q;
    logic [4:0] diamonds_q;
    logic       start_rise;

    assign start_rise = gf.start_pressed & ~start_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            start_q      <= 1'b1;    // a button held through reset produces no edge
            frame_q      <= 8'd0;
            freeze_q     <= 1'b1;
            level_load_q <= 1'b0;
            respawn_q    <= 1'b0;
            level_q      <= 4'd1;
            lives_q      <= 3'd0;
            diamonds_q   <= 5'd0;
        end else begin
            start_q      <= gf.start_pressed;
            level_load_q <= 1'b0;
            respawn_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_rise) begin
                        lives_q      <= LIVES_INIT;
                        level_q      <= 4'd1;
                        diamonds_q   <= DIAMONDS_INIT;
                        level_load_q <= 1'b1;
                        frame_q      <= 8'd0;
                        state_q      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (gf.startOfFrame) begin
                        freeze_q <= 1'b0;
                        frame_q  <= 8'd0;
                        state_q  <= S_PLAY;
                    end
                end
                S_PLAY: begin
                    // The diamond has priority. A death in the same cycle counts only if the level is not cleared.
                    if (gf.player_eat_dimond && diamonds_q == 5'd1) begin
                        diamonds_q <= 5'd0;
                        freeze_q   <= 1'b1;
                        frame_q    <= 8'd0;
                        state_q    <= S_LEVEL_DONE;
                    end else begin
                        if (gf.player_eat_dimond) begin
                            diamonds_q <= diamonds_q - 5'd1;
                        end
                        if (gf.player_died && lives_q != 3'd0) begin
                            lives_q  <= lives_q - 3'd1;
                            freeze_q <= 1'b1;
                            frame_q  <= 8'd0;
                            state_q  <= S_DYING;
                        end
                    end
                end
                S_DYING: begin
                    if (gf.startOfFrame) begin
                        if (frame_q == DEATH_LAST) begin
                            frame_q <= 8'd0;
                            if (lives_q == 3'd0) begin
                                state_q <= S_GAME_OVER;
                            end else begin
                                respawn_q <= 1'b1;
                                state_q   <= S_RESPAWN;
                            end
                        end else begin
                            frame_q <= frame_q + 8'd1;
                        end
                    end
                end
                S_RESPAWN: begin
                    freeze_q <= 1'b0;
                    frame_q  <= 8'd0;
                    state_q  <= S_PLAY;
                end
                S_LEVEL_DONE: begin
                    if (gf.startOfFrame) begin
                        if (frame_q == CLEAR_LAST) begin
                            level_q      <= (level_q == LEVEL_LAST) ? 4'd1 : level_q + 4'd1;
                            diamonds_q   <= DIAMONDS_INIT;
                            level_load_q <= 1'b1;
                            frame_q      <= 8'd0;
                            state_q      <= S_LOAD;
                        end else begin
                            frame_q <= frame_q + 8'd1;
                        end
                    end
                end
                S_GAME_OVER: begin
                    // The counter saturates at the hold time, so Start stays accepted however long the screen is shown.
                    if (start_rise && frame_q == OVER_DONE) begin
                        frame_q <= 8'd0;
                        state_q <= S_IDLE;
                    end else if (gf.startOfFrame && frame_q != OVER_DONE) begin
                        frame_q <= frame_q + 8'd1;
                    end
                end
                default: begin
                    freeze_q <= 1'b1;
                    frame_q  <= 8'd0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

    assign gf.game_state    = state_q;
    assign gf.freeze        = freeze_q;
    assign gf.level_load    = level_load_q;
    assign gf.respawn       = respawn_q;
    assign gf.level         = level_q;
    assign gf.lives         = lives_q;
    assign gf.diamonds_left = diamonds_q;
endmodule

// File: tb/tb_game_flow_controller.sv
// Directed vector bench for game_flow_controller, using small parameters.
// Each record holds the quiet cycles before the vector, its inputs and the outputs expected one edge later.
module tb_game_flow_controller;
    logic clk;
    logic reset;
    game_flow_if gf();

    game_flow_controller #(
        .DIAMONDS_PER_LEVEL(2),
        .MAX_LEVEL(2),
        .START_LIVES(2),
        .DEATH_FRAMES(3),
        .CLEAR_FRAMES(2),
        .OVER_FRAMES(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .gf(gf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int gap;
        bit rst, start, sof, died, eat;
        int st, frz, ll, rs, lvl, liv, dia;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs[$];

    function automatic vec_t mk(int gap, bit rst, bit start, bit sof, bit died, bit eat,
                                int st, int frz, int ll, int rs, int lvl, int liv, int dia);
        vec_t v;
        v.gap = gap; v.rst = rst; v.start = start; v.sof = sof; v.died = died; v.eat = eat;
        v.st = st; v.frz = frz; v.ll = ll; v.rs = rs; v.lvl = lvl; v.liv = liv; v.dia = dia;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        reset = 1'b0;
        gf.start_pressed = v.start;
        gf.startOfFrame = 1'b0;
        gf.player_died = 1'b0;
        gf.player_eat_dimond = 1'b0;
        repeat (v.gap) tick();
        reset = v.rst;
        gf.startOfFrame = v.sof;
        gf.player_died = v.died;
        gf.player_eat_dimond = v.eat;
        tick();
        chk({tag, ".game_state"},    int'(gf.game_state),    v.st);
        chk({tag, ".freeze"},        int'(gf.freeze),        v.frz);
        chk({tag, ".level_load"},    int'(gf.level_load),    v.ll);
        chk({tag, ".respawn"},       int'(gf.respawn),       v.rs);
        chk({tag, ".level"},         int'(gf.level),         v.lvl);
        chk({tag, ".lives"},         int'(gf.lives),         v.liv);
        chk({tag, ".diamonds_left"}, int'(gf.diamonds_left), v.dia);
        $display("%s: st=%0d frz=%0d ll=%0d rs=%0d lvl=%0d lives=%0d dia=%0d",
                 tag, gf.game_state, gf.freeze, gf.level_load, gf.respawn,
                 gf.level, gf.lives, gf.diamonds_left);
    endtask

    initial begin
        reset = 1'b1;
        gf.start_pressed = 1'b1;
        gf.startOfFrame = 1'b0;
        gf.player_died = 1'b0;
        gf.player_eat_dimond = 1'b0;

        //                gap rst st sof die eat   st frz ll rs lvl liv dia
        // Reset with Start held, 50 held cycles, then release and press.
        vecs.push_back(mk( 0, 1, 1, 0, 0, 0,    0, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk(49, 0, 1, 0, 0, 0,    0, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk( 0, 0, 0, 0, 0, 0,    0, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk( 0, 0, 1, 0, 0, 0,    1, 1, 1, 0, 1, 2, 2));
        vecs.push_back(mk( 0, 0, 1, 0, 0, 0,    1, 1, 0, 0, 1, 2, 2));
        vecs.push_back(mk(18, 0, 0, 1, 0, 0,    2, 0, 0, 0, 1, 2, 2));
        // Clear level 1 and advance to level 2.
        vecs.push_back(mk( 0, 0, 0, 0, 0, 1,    2, 0, 0, 0, 1, 2, 1));
        vecs.push_back(mk( 3, 0, 0, 0, 0, 1,    5, 1, 0, 0, 1, 2, 0));
        vecs.push_back(mk(19, 0, 0, 1, 0, 0,    5, 1, 0, 0, 1, 2, 0));
        vecs.push_back(mk(19, 0, 0, 1, 0, 0,    1, 1, 1, 0, 2, 2, 2));
        vecs.push_back(mk( 0, 0, 0, 0, 0, 0,    1, 1, 0, 0, 2, 2, 2));
        vecs.push_back(mk(18, 0, 0, 1, 0, 0,    2, 0, 0, 0, 2, 2, 2));
        // Clear level 2; the level wraps back to 1.
        vecs.push_back(mk( 0, 0, 0, 0, 0, 1,    2, 0, 0, 0, 2, 2, 1));
        vecs.push_back(mk( 0, 0, 0, 0, 0, 1,    5, 1, 0, 0, 2, 2, 0));
        vecs.push_back(mk(19, 0, 0, 1, 0, 0,    5, 1, 0, 0, 2, 2, 0));
        vecs.push_back(mk(19, 0, 0, 1, 0, 0,    1, 1, 1, 0, 1, 2, 2));
        vecs.push_back(mk(18, 0, 0, 1, 0, 0,    2, 0, 0, 0, 1, 2, 2));
        // Death, then respawn after 3 frames plus 1 cycle, with diamonds kept.
        vecs.push_back(mk( 0, 0, 0, 0, 0, 1,    2, 0, 0, 0, 1, 2, 1));
        vecs.push_back(mk( 0, 0, 0, 0, 1, 0,    3, 1, 0, 0, 1, 1, 1));
        vecs.push_back(mk(19, 0, 0, 1, 0, 0,    3, 1, 0, 0, 1, 1, 1));
        vecs.push_back(mk(19, 0, 0, 1, 0, 0,    3, 1, 0, 0, 1, 1, 1));
        vecs.push_back(mk(19, 0, 0, 1, 0, 0,    4, 1, 0, 1, 1, 1, 1));
        vecs.push_back(mk( 0, 0, 0, 0, 0, 0,    2, 0, 0, 0, 1, 1, 1));
        // Death together with the final diamond: the level clears and lives are kept.
        vecs.push_back(mk( 0, 0, 0, 0, 1, 1,    5, 1, 0, 0, 1, 1, 0));
        vecs.push_back(mk(19, 0, 0, 1, 0, 0,    5, 1, 0, 0, 1, 1, 0));
        vecs.push_back(mk(19, 0, 0, 1, 0, 0,    1, 1, 1, 0, 2, 1, 2));
        vecs.push_back(mk(18, 0, 0, 1, 0, 0,    2, 0, 0, 0, 2, 1, 2));
        // Death together with a non-final diamond: both count, and the game ends.
        vecs.push_back(mk( 0, 0, 0, 0, 1, 1,    3, 1, 0, 0, 2, 0, 1));
        vecs.push_back(mk(19, 0, 0, 1, 0, 0,    3, 1, 0, 0, 2, 0, 1));
        vecs.push_back(mk(19, 0, 0, 1, 0, 0,    3, 1, 0, 0, 2, 0, 1));
        vecs.push_back(mk(19, 0, 0, 1, 0, 0,    6, 1, 0, 0, 2, 0, 1));
        // Game over: Start is ignored before 2 frames and accepted after them.
        vecs.push_back(mk( 9, 0, 1, 0, 0, 0,    6, 1, 0, 0, 2, 0, 1));
        vecs.push_back(mk( 0, 0, 0, 0, 0, 0,    6, 1, 0, 0, 2, 0, 1));
        vecs.push_back(mk( 9, 0, 0, 1, 0, 0,    6, 1, 0, 0, 2, 0, 1));
        vecs.push_back(mk( 0, 0, 1, 0, 0, 0,    6, 1, 0, 0, 2, 0, 1));
        vecs.push_back(mk( 0, 0, 0, 0, 0, 0,    6, 1, 0, 0, 2, 0, 1));
        vecs.push_back(mk(18, 0, 0, 1, 0, 0,    6, 1, 0, 0, 2, 0, 1));
        vecs.push_back(mk( 0, 0, 1, 0, 0, 0,    0, 1, 0, 0, 2, 0, 1));
        // Pulses in IDLE are ignored.
        vecs.push_back(mk( 0, 0, 0, 0, 1, 1,    0, 1, 0, 0, 2, 0, 1));

        foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));

        // Reset asserted while respawn is high truncates the pulse.
        apply(mk( 0, 0, 1, 0, 0, 0,    1, 1, 1, 0, 1, 2, 2), "h_start");
        apply(mk(18, 0, 0, 1, 0, 0,    2, 0, 0, 0, 1, 2, 2), "h_play");
        apply(mk( 0, 0, 0, 0, 1, 0,    3, 1, 0, 0, 1, 1, 2), "h_die");
        apply(mk(19, 0, 0, 1, 0, 0,    3, 1, 0, 0, 1, 1, 2), "h_frame1");
        apply(mk(19, 0, 0, 1, 0, 0,    3, 1, 0, 0, 1, 1, 2), "h_frame2");
        apply(mk(19, 0, 0, 1, 0, 0,    4, 1, 0, 1, 1, 1, 2), "h_respawn");
        apply(mk( 0, 1, 0, 0, 0, 0,    0, 1, 0, 0, 1, 0, 0), "h_reset");
        apply(mk( 0, 0, 0, 0, 1, 1,    0, 1, 0, 0, 1, 0, 0), "h_idle_pulses");
        apply(mk( 3, 0, 0, 1, 0, 1,    0, 1, 0, 0, 1, 0, 0), "h_idle_sof");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
